// File: rtl/ifetch.sv
// ifetch: instruction fetch unit with an in-order response buffer.
// Issues word-aligned imem requests, buffers returned words, hands them to decode.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   imem_req_valid/ready/addr fetch request handshake and word address
//   imem_rsp_valid/data       in-order instruction responses (no backpressure)
//   redirect, redirect_pc     taken jump/branch and its target
//   inst_valid/ready          decode handshake
//   inst, inst_pc             head-of-buffer instruction word and its address
//
// Parameters: RESET_PC (first fetch address), MAX_OUT (requests in flight).
// Macro IFETCH_BUF2_EN: defined -> 2-entry buffer, undefined -> 1-entry buffer.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

`ifdef IFETCH_BUF2_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   rpc_q, rpc_d;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   inst_d [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   pc_d   [DEPTH];

    logic          req_hs, rsp_ok, push, pop;
    logic [OW-1:0] live;
    logic [31:0]   occ;
    logic [31:0]   tgt;
    logic          unused_bits;

    assign unused_bits = ^redirect_pc[1:0];
    assign tgt = {redirect_pc[31:2], 2'b00};

    // Requests still owed to the buffer (stale ones are excluded).
    assign live = out_q - drop_q;
    assign pop  = inst_valid && inst_ready;
    // The slot freed by this cycle's decode handshake is reusable now,
    // which is what lets a 1-cycle imem sustain full throughput.
    assign occ  = 32'(cnt_q) - 32'(pop) + 32'(live);

    assign imem_req_valid = !rst && !redirect
                          && (occ < DEPTH)
                          && (32'(out_q) < MAX_OUT);
    assign imem_req_addr  = {fpc_q[31:2], 2'b00};
    assign inst_valid     = (cnt_q != '0);
    assign inst           = inst_q[0];
    assign inst_pc        = pc_q[0];

    assign req_hs = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is ignored entirely.
    assign rsp_ok = imem_rsp_valid && (out_q != '0);
    assign push   = rsp_ok && !redirect && (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        rpc_d   = rpc_q;
        out_d   = out_q + OW'(req_hs) - OW'(rsp_ok);
        drop_d  = drop_q;
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        for (int i = 0; i < int'(DEPTH); i++) begin
            inst_d[i] = inst_q[i];
            pc_d[i]   = pc_q[i];
        end

        if (req_hs) begin
            fpc_d = fpc_q + 32'd4;
        end

        if (pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                inst_d[i] = inst_q[i+1];
                pc_d[i]   = pc_q[i+1];
            end
        end

        // Live responses come back in fetch order, so their address is
        // simply the next sequential pc since the last redirect.
        if (push) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (32'(i) == 32'(cnt_q) - 32'(pop)) begin
                    inst_d[i] = imem_rsp_data;
                    pc_d[i]   = rpc_q;
                end
            end
            rpc_d = rpc_q + 32'd4;
        end

        if (state_q == S_FLUSH && rsp_ok) begin
            drop_d = drop_q - OW'(1'b1);
        end

        if (redirect) begin
            fpc_d  = tgt;
            rpc_d  = tgt;
            cnt_d  = '0;
            drop_d = out_q - OW'(rsp_ok);
        end

        state_d = (drop_d != '0) ? S_FLUSH : S_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            fpc_q   <= RESET_PC;
            rpc_q   <= {RESET_PC[31:2], 2'b00};
            out_q   <= '0;
            drop_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            rpc_q   <= rpc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_q[i] <= inst_d[i];
                pc_q[i]   <= pc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed and randomized bench for ifetch.
// imem responder and a queue-based reference model of the fetch stream.
module tb_ifetch;

`ifdef IFETCH_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam bit          NEED_RSP = (DEPTH == 2);
    localparam int          GAP      = (DEPTH == 2) ? 1 : 2;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    ifetch #(
        .RESET_PC(RST_PC),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } rq_t;

    rq_t         rq[$];
    int          cyc, vecs, errs;
    int          buf_n, ndec, nreq, last_dec_cyc;
    int          lat_lo, lat_hi;
    logic [31:0] mfpc, exp_pc, last_dec_pc, last_req_addr;
    bit          p_hold;
    logic [31:0] p_inst, p_pc;
    bit          rdy_req, rdy_inst, do_redir, redir_cond, spur, fired;
    logic [31:0] redir_tgt;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step();
        int          live_n;
        bit          rd, dh, dh_m, rv, rs, sp, exp_rv;
        logic [31:0] a, tgt, opc;
        rq_t         e;
        sp = 1'b0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(rq[0].addr);
        end else if (spur && rq.size() == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            sp = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = rdy_req;
        inst_ready     = rdy_inst;
        redirect       = do_redir && !redir_cond;
        redirect_pc    = redir_tgt;
        #1;
        if (redir_cond && inst_valid && inst_ready && !sp
            && (imem_rsp_valid || !NEED_RSP)) begin
            redirect = 1'b1;
            fired    = 1'b1;
            #1;
        end
        rd   = redirect;
        dh_m = (buf_n != 0) && rdy_inst;
        live_n = 0;
        foreach (rq[i]) if (rq[i].live) live_n++;
        exp_rv = !rd && (buf_n - int'(dh_m) + live_n < DEPTH)
               && (rq.size() < MAX_OUT);
        chk("inst_valid", 32'(inst_valid), 32'(buf_n != 0));
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (imem_req_valid) chk("req_addr", imem_req_addr, mfpc);
        dh = inst_valid && inst_ready;
        if (dh) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", inst, memf(exp_pc));
        end
        if (p_hold) begin
            chk("hold_inst", inst, p_inst);
            chk("hold_pc", inst_pc, p_pc);
        end
        p_hold = inst_valid && !inst_ready && !rd;
        p_inst = inst;
        p_pc   = inst_pc;
        rv  = imem_req_valid && imem_req_ready;
        rs  = imem_rsp_valid && !sp;
        a   = imem_req_addr;
        tgt = {redirect_pc[31:2], 2'b00};
        opc = inst_pc;
        @(posedge clk);
        if (rs) begin
            if (!rd && rq[0].live) buf_n++;
            void'(rq.pop_front());
        end
        if (dh) begin
            if (buf_n > 0) buf_n--;
            exp_pc = exp_pc + 32'd4;
            ndec++;
            last_dec_pc  = opc;
            last_dec_cyc = cyc;
        end
        if (rd) begin
            foreach (rq[i]) rq[i].live = 1'b0;
            buf_n  = 0;
            exp_pc = tgt;
            mfpc   = tgt;
        end
        if (rv) begin
            e.addr = a;
            e.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
            e.live = 1'b1;
            rq.push_back(e);
            mfpc = mfpc + 32'd4;
            nreq++;
            last_req_addr = a;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rq.delete();
        buf_n  = 0;
        mfpc   = RST_PC;
        exp_pc = RST_PC;
        p_hold = 1'b0;
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, RST_PC);
    endtask

    initial begin
        int dq[$];
        logic [31:0] pq[$];
        int base, d0, n0;
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        cyc = 0; vecs = 0; errs = 0;
        buf_n = 0; ndec = 0; nreq = 0; last_dec_cyc = 0;
        mfpc = RST_PC; exp_pc = RST_PC;
        last_dec_pc = '0; last_req_addr = '0;
        p_hold = 1'b0; p_inst = '0; p_pc = '0;
        rdy_req = 1'b0; rdy_inst = 1'b0; do_redir = 1'b0;
        redir_cond = 1'b0; spur = 1'b0; fired = 1'b0;
        redir_tgt = '0;
        lat_lo = 1; lat_hi = 1;
        @(negedge clk);
        do_reset();

        // Boot stream with a 1-cycle imem.
        rdy_req = 1'b1; rdy_inst = 1'b1;
        base = cyc;
        for (int k = 0; k < 10; k++) begin
            d0 = ndec;
            step();
            if (ndec != d0) begin
                dq.push_back(last_dec_cyc - base);
                pq.push_back(last_dec_pc);
            end
        end
        chk("boot_ndec", 32'(dq.size() >= 3), 32'd1);
        if (dq.size() >= 3) begin
            chk("boot_pc0", pq[0], RST_PC);
            chk("boot_pc1", pq[1], RST_PC + 32'd4);
            chk("boot_pc2", pq[2], RST_PC + 32'd8);
            chk("boot_cyc0", 32'(dq[0]), 32'd2);
            chk("boot_gap1", 32'(dq[1] - dq[0]), 32'(GAP));
            chk("boot_gap2", 32'(dq[2] - dq[1]), 32'(GAP));
        end

        // Decode stall: requests stop once the buffer is full.
        rdy_inst = 1'b0;
        repeat (5) step();
        #1;
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_inst_valid", 32'(inst_valid), 32'd1);
        rdy_inst = 1'b1;
        repeat (8) step();

        // Redirect with requests outstanding, 3-cycle imem.
        lat_lo = 3; lat_hi = 3;
        for (int k = 0; k < 20 && rq.size() < DEPTH; k++) step();
        chk("pre_redir_out", 32'(rq.size()), 32'(DEPTH));
        do_redir = 1'b1; redir_tgt = 32'h0000_0103;
        step();
        do_redir = 1'b0;
        n0 = nreq; d0 = ndec;
        for (int k = 0; k < 20 && nreq == n0; k++) step();
        chk("redir_req_seen", 32'(nreq > n0), 32'd1);
        chk("redir_req_addr", last_req_addr, 32'h0000_0100);
        for (int k = 0; k < 30 && ndec == d0; k++) step();
        chk("redir_dec_seen", 32'(ndec > d0), 32'd1);
        chk("redir_first_pc", last_dec_pc, 32'h0000_0100);

        // Redirect in the same cycle as a decode handshake (and response).
        lat_lo = 1; lat_hi = 1;
        redir_cond = 1'b1; redir_tgt = 32'h0000_0200; fired = 1'b0;
        for (int k = 0; k < 20 && !fired; k++) step();
        redir_cond = 1'b0;
        chk("cond_redir_fired", 32'(fired), 32'd1);
        d0 = ndec;
        for (int k = 0; k < 20 && ndec == d0; k++) step();
        chk("cond_dec_seen", 32'(ndec > d0), 32'd1);
        chk("cond_first_pc", last_dec_pc, 32'h0000_0200);

        // Fetch pc wrap.
        lat_lo = 1; lat_hi = 2;
        do_redir = 1'b1; redir_tgt = 32'hFFFF_FFF8;
        step();
        do_redir = 1'b0;
        d0 = ndec;
        for (int k = 0; k < 40 && ndec < d0 + 3; k++) step();
        chk("wrap_dec_seen", 32'(ndec >= d0 + 3), 32'd1);
        chk("wrap_pc", last_dec_pc, 32'h0000_0000);

        // Reset mid-flight, then a stray response with nothing outstanding.
        lat_lo = 3; lat_hi = 3;
        repeat (3) step();
        do_reset();
        spur = 1'b1;
        step();
        spur = 1'b0;
        d0 = ndec;
        for (int k = 0; k < 20 && ndec == d0; k++) step();
        chk("post_rst_dec_seen", 32'(ndec > d0), 32'd1);
        chk("post_rst_pc", last_dec_pc, RST_PC);

        // Randomized traffic.
        lat_lo = 1; lat_hi = 4;
        for (int k = 0; k < 3000; k++) begin
            rdy_req   = ($urandom_range(3, 0) != 0);
            rdy_inst  = ($urandom_range(9, 0) < 7);
            do_redir  = ($urandom_range(24, 0) == 0);
            redir_tgt = $urandom;
            spur      = ($urandom_range(9, 0) == 0);
            step();
        end
        do_redir = 1'b0; spur = 1'b0;
        rdy_req = 1'b1; rdy_inst = 1'b1;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
